// File: rtl/prll_2_srl_conv.sv
// rtl/prll_2_srl_conv.sv - parallel-to-serial converter with one-word holding register
//
// Purpose: accepts WIDTH-bit words over a load/ready handshake and shifts them out
// one bit per clock, framed by valid_o and last_o. A holding register lets the
// next word queue up behind the one in flight so words stream without idle bits.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   prll_in  parallel word to transmit (WIDTH bits)
//   load_i   prll_in is valid this cycle
//   ready_o  a word can be accepted this cycle
//   srl_o    serial data bit
//   valid_o  srl_o carries a data bit this cycle
//   last_o   srl_o carries the final bit of the current word

module prll_2_srl_conv #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] prll_in,
  input  logic             load_i,
  output logic             ready_o,
  output logic             srl_o,
  output logic             valid_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;

  logic accept;
  logic at_last;
  logic load_shreg;   // prll_in goes straight into the shift register
  logic load_hold;    // held word moves into the shift register
  logic shift_en;     // advance one bit within the current word
  logic fill_hold;    // prll_in is parked in the holding register

  // ready_o depends only on registered state, so there is no input-to-output path.
  assign ready_o = !hold_full;
  assign accept  = load_i && ready_o;
  assign at_last = (cnt == LAST_BIT);

  // Shift toward whichever end feeds srl_o.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    valid_o    = 1'b0;
    last_o     = 1'b0;
    srl_o      = 1'b0;
    load_shreg = 1'b0;
    load_hold  = 1'b0;
    shift_en   = 1'b0;
    fill_hold  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          load_shreg = 1'b1;
          state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        valid_o = 1'b1;
        srl_o   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        last_o  = at_last;
        if (!at_last) begin
          shift_en  = 1'b1;
          fill_hold = accept;
        end else if (hold_full) begin
          // ready_o is low here, so no accept can collide with the hold transfer.
          load_hold = 1'b1;
        end else if (accept) begin
          // Hold is empty: the new word bypasses it and follows with no gap.
          load_shreg = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load_shreg) begin
        shreg <= prll_in;
        cnt   <= '0;
      end else if (load_hold) begin
        shreg     <= hold;
        hold_full <= 1'b0;
        cnt       <= '0;
      end else if (shift_en) begin
        shreg <= shreg_shifted;
        cnt   <= cnt + 1'b1;
      end

      if (fill_hold) begin
        hold      <= prll_in;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prll_2_srl_conv.sv
// tb/tb_prll_2_srl_conv.sv - scoreboard bench for prll_2_srl_conv, MSB-first and LSB-first instances

module tb_prll_2_srl_conv;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load_i;
  logic [W-1:0] prll_in;

  logic ready_m, srl_m, valid_m, last_m;
  logic ready_l, srl_l, valid_l, last_l;

  // Each entry is {last flag, data bit} for one expected serial cycle.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic       rdy_m = 1'b1;
  logic       rdy_l = 1'b1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  prll_2_srl_conv #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk     (clk),
    .reset_n (reset_n),
    .prll_in (prll_in),
    .load_i  (load_i),
    .ready_o (ready_m),
    .srl_o   (srl_m),
    .valid_o (valid_m),
    .last_o  (last_m)
  );

  prll_2_srl_conv #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk     (clk),
    .reset_n (reset_n),
    .prll_in (prll_in),
    .load_i  (load_i),
    .ready_o (ready_l),
    .srl_o   (srl_l),
    .valid_o (valid_l),
    .last_o  (last_l)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  // A word occupies W serial slots; the block can take another word only while
  // at most one word's worth of bits is still outstanding.
  task automatic mon(input string nm, input int sz, input logic [1:0] head,
                     input logic rdy, input logic vld, input logic srl, input logic lst);
    chk({nm, " ready"}, rdy, sz <= W);
    if (sz > 0) begin
      chk({nm, " valid"}, vld, 1'b1);
      chk({nm, " bit"}, srl, head[0]);
      chk({nm, " last"}, lst, head[1]);
    end else begin
      chk({nm, " idle valid"}, vld, 1'b0);
      chk({nm, " idle srl"}, srl, 1'b0);
      chk({nm, " idle last"}, lst, 1'b0);
    end
  endtask

  // Monitor: compare every cycle against the head of each scoreboard queue.
  always @(negedge clk) begin
    mon("msb", q_m.size(), (q_m.size() > 0) ? q_m[0] : 2'b00, ready_m, valid_m, srl_m, last_m);
    rdy_m = (q_m.size() <= W);
    if (q_m.size() > 0) void'(q_m.pop_front());
    mon("lsb", q_l.size(), (q_l.size() > 0) ? q_l[0] : 2'b00, ready_l, valid_l, srl_l, last_l);
    rdy_l = (q_l.size() <= W);
    if (q_l.size() > 0) void'(q_l.pop_front());
  end

  // Reference model: an accepted word expands into its W bits in transmit order.
  always @(posedge clk) begin
    if (reset_n && load_i) begin
      if (rdy_m) for (int i = 0; i < W; i++) q_m.push_back({i == W - 1, prll_in[W-1-i]});
      if (rdy_l) for (int i = 0; i < W; i++) q_l.push_back({i == W - 1, prll_in[i]});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    load_i  = 1'b1;
    prll_in = w;
    while (ready_m !== 1'b1) begin
      if (n == 50) begin
        chk("send timeout", 1'b0, 1'b1);
        break;
      end
      idle(1);
      n++;
    end
    idle(1);
    load_i = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    load_i  = 1'b1;
    prll_in = 4'hF;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b1;
    load_i  = 1'b0;
    idle(6);

    send(4'b1011);
    idle(6);

    send(4'hA);
    send(4'h5);
    idle(10);

    send(4'hC);
    idle(3);
    send(4'h3);
    idle(8);

    send(4'hA);
    send(4'h5);
    load_i  = 1'b1;
    prll_in = 4'hF;
    idle(2);
    load_i = 1'b0;
    idle(10);

    send(4'h9);
    idle(1);
    reset_n = 1'b0;
    q_m.delete();
    q_l.delete();
    idle(2);
    reset_n = 1'b1;
    idle(6);

    send(4'b0001);
    idle(6);

    repeat (400) begin
      load_i  = 1'($urandom_range(0, 1));
      prll_in = W'($urandom);
      idle(1);
    end
    load_i = 1'b0;
    idle(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prll_2_srl_conv.md
# prll_2_srl_conv

Parallel-to-serial converter: the transmit-side counterpart of `srl_2_prll_conv`. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line. A serial-valid strobe and a last-bit marker frame each word. A one-word holding register lets consecutive words stream with no idle bit between them.

## Interface
Parameters:
- WIDTH, 4: word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is transmitted first, so `srl_2_prll_conv` reassembles the word unchanged; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- prll_in  input  WIDTH  parallel word to transmit.
- load_i  input  1  prll_in is valid this cycle.
- ready_o  output  1  block can accept a word this cycle.
- srl_o  output  1  serial data bit.
- valid_o  output  1  srl_o carries a data bit this cycle.
- last_o  output  1  srl_o carries the final bit of the current word.

## Operation
- Accept: a word is accepted on a rising edge where load_i=1 and ready_o=1. If load_i=1 while ready_o=0, the word is ignored and nothing is captured.
- Storage:
  - shreg: WIDTH-bit shift register.
  - cnt: bit counter, $clog2(WIDTH) bits.
  - hold / hold_full: one-word holding register and its full flag.
  - FSM with two states, IDLE and SHIFT.
- ready_o = !hold_full. It depends only on registered state.
- IDLE:
  - valid_o=0, last_o=0, srl_o=0.
  - On accept: prll_in loads into shreg, cnt=0, next state SHIFT.
- SHIFT:
  - valid_o=1. srl_o = shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
  - last_o = (cnt == WIDTH-1).
  - Each edge with cnt < WIDTH-1: shift shreg toward the output end, cnt+1.
  - An accept while cnt < WIDTH-1 writes prll_in into hold and sets hold_full.
- Word boundary (edge where cnt == WIDTH-1), priority order:
  1. hold_full=1: hold moves to shreg, hold_full clears, cnt=0, stay in SHIFT. ready_o was 0 this cycle, so no new accept can occur.
  2. hold_full=0 and an accept occurs: prll_in bypasses hold and loads straight into shreg, cnt=0, stay in SHIFT.
  3. Otherwise: next state IDLE.
- Throughput: one bit per clock. Words presented ahead of need are sent with no gap between them.
- Reset (reset_n low at any time, including mid-word):
  - Immediately clears state to IDLE, cnt=0, shreg=0, hold_full=0.
  - Any word in flight and any held word are discarded.
  - Outputs while reset is low: srl_o=0, valid_o=0, last_o=0, ready_o=1.
  - load_i is ignored while reset_n is low.

## Timing
- Latency: a word accepted at edge k presents its first bit in the cycle after edge k (k+1). Its last bit appears in cycle k+WIDTH with last_o=1.
- valid_o is high for exactly WIDTH cycles per word and is continuous across back-to-back words.
- last_o is high for exactly one cycle per word, coincident with that word's final bit.
- Hold timing: after an accept into hold at edge j, ready_o is 0 from cycle j+1 until the word-boundary edge. It returns to 1 in the cycle after that edge.
- Outputs change only on clk rising edges or on reset_n assertion; there is no combinational path from input to output.

## Test plan
- Reset: assert reset_n=0 with load_i=1 and prll_in=4'hF -> srl_o=0, valid_o=0, last_o=0, ready_o=1, nothing transmitted after release.
- Single word: WIDTH=4, accept 4'b1011 at edge k -> srl_o = 1,0,1,1 in cycles k+1 through k+4; valid_o high for those 4 cycles only; last_o high in k+4 only; then IDLE.
- Back-to-back via hold: accept 4'hA at edge k, then 4'h5 at edge k+1 -> 8 contiguous valid bits 1010_0101; ready_o=0 from k+2 through k+4, back to 1 at k+5; last_o high at k+4 and k+8.
- Bypass: hold empty, accept 4'h3 exactly on the edge ending 4'hC's last bit -> bits 1100_0011 with no gap; hold_full never set.
- Ignored load: with hold full, drive load_i=1 with prll_in=4'hF -> 4'hF never appears on srl_o; the held word is sent intact.
- Mid-word reset and LSB-first:
  - Pulse reset_n low after 2 bits of 4'h9 -> valid_o drops immediately and the word is not resumed.
  - With MSB_FIRST=0, 4'b0001 is sent as 1,0,0,0.
